uart_boot_loader: RTL and testbench

- Serial boot loader between the board UART pin and the CPU instruction fetch port.
- Receives a framed program image over 8N1 UART and stores it as 32-bit words in an internal instruction memory.
- Serves the CPU's instruction reads from that memory.
- Holds the CPU disabled until a complete image with a correct checksum has been loaded.

---
 rtl/uart_boot_loader_pkg.sv | 14 +
 rtl/uart_boot_loader_rx_byte.sv | 92 +++++++++
 rtl/uart_boot_loader.sv | 150 +++++++++++++++
 tb/tb_uart_boot_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_boot_loader_pkg.sv
// Shared constants and state encodings for the UART boot loader and its byte receiver.
package uart_boot_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE} load_state_t;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_boot_loader_rx_byte.sv
// 8N1 byte receiver: input synchronizer, mid-bit sampling and stop-bit framing check.
module uart_rx_byte
    import uart_boot_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic            rx_meta, rx_s, rx_prev;
    rx_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]      bit_idx, bit_n;
    logic [7:0]      shift, shift_n;

    // Synchronizer and edge-detect history are pure data; they flush within three clocks.
    always_ff @(posedge clk) begin
        rx_meta <= uart_rx;
        rx_s    <= rx_meta;
        rx_prev <= rx_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
        end
        shift <= shift_n;
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_n      = bit_idx;
        shift_n    = shift;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (state)
            RX_IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_n = RX_START;
                    cnt_n   = '0;
                end
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = rx_s ? RX_IDLE : RX_BITS;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RX_BITS: begin
                if (cnt == FULL_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift[7:1]};
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                    else                 bit_n   = bit_idx + 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt == FULL_LAST) begin
                    state_n    = RX_IDLE;
                    byte_valid = rx_s;
                    frame_err  = !rx_s;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    assign byte_data = shift;

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a checksummed program image from UART into instruction memory and gates the CPU on it.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int CLK_HZ         = 27000000,
    parameter int BAUD           = 115200,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 2700000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    input  logic [ADDR_W-1:0] rom_address,
    output logic [31:0]       rom_data,
    output logic              cpu_enable,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int DEPTH        = 2 ** ADDR_W;
    localparam int TMO_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [ADDR_W:0]  DEPTH_N  = (ADDR_W + 1)'(DEPTH);

    logic [7:0] byte_data;
    logic       byte_valid, frame_err;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    load_state_t      state, state_n;
    logic [31:0]      mem [DEPTH];
    logic [ADDR_W:0]  n_words, word_addr;
    logic [1:0]       byte_idx;
    logic [7:0]       sum;
    logic [23:0]      asm_word;
    logic [TMO_W-1:0] tmo_cnt;
    logic start_load, latch_len, take_data, mem_we, load_ok, load_fail;
    logic in_frame, abort;

    always_comb begin
        state_n    = state;
        start_load = 1'b0;
        latch_len  = 1'b0;
        take_data  = 1'b0;
        mem_we     = 1'b0;
        load_ok    = 1'b0;
        load_fail  = 1'b0;
        in_frame   = (state == LEN) || (state == DATA) || (state == CSUM);
        abort      = in_frame && (frame_err || (tmo_cnt == TMO_LAST));
        case (state)
            IDLE, DONE: begin
                if (byte_valid && byte_data == SYNC_BYTE) begin
                    state_n    = LEN;
                    start_load = 1'b1;
                end
            end
            LEN: begin
                if (abort) begin
                    state_n = IDLE;  load_fail = 1'b1;
                end else if (byte_valid) begin
                    state_n = DATA;  latch_len = 1'b1;
                end
            end
            DATA: begin
                if (abort) begin
                    state_n = IDLE;  load_fail = 1'b1;
                end else if (byte_valid) begin
                    take_data = 1'b1;
                    if (byte_idx == 2'd3) begin
                        mem_we = 1'b1;
                        if (word_addr == n_words - 1'b1) state_n = CSUM;
                    end
                end
            end
            CSUM: begin
                if (abort) begin
                    state_n = IDLE;  load_fail = 1'b1;
                end else if (byte_valid) begin
                    if (byte_data == sum) begin
                        state_n = DONE;  load_ok = 1'b1;
                    end else begin
                        state_n = IDLE;  load_fail = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cpu_enable   <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
            tmo_cnt      <= '0;
        end else begin
            state <= state_n;
            if (start_load) begin
                cpu_enable <= 1'b0;
                load_error <= 1'b0;
            end
            if (load_ok) begin
                cpu_enable   <= 1'b1;
                words_loaded <= n_words;
            end
            if (load_fail) load_error <= 1'b1;
            if (byte_valid || !in_frame) tmo_cnt <= '0;
            else if (tmo_cnt != TMO_LAST) tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Frame datapath: initialised by the length byte, so it needs no reset.
    always_ff @(posedge clk) begin
        if (latch_len) begin
            n_words   <= (byte_data == 8'd0) ? DEPTH_N : (ADDR_W + 1)'(byte_data);
            word_addr <= '0;
            byte_idx  <= '0;
            sum       <= '0;
        end
        if (take_data) begin
            sum      <= sum + byte_data;
            byte_idx <= byte_idx + 1'b1;
            case (byte_idx)
                2'd0:    asm_word[7:0]   <= byte_data;
                2'd1:    asm_word[15:8]  <= byte_data;
                2'd2:    asm_word[23:16] <= byte_data;
                default: word_addr       <= word_addr + 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !reset) mem[word_addr[ADDR_W-1:0]] <= {byte_data, asm_word};
    end

    // Read-first port: a same-cycle write to rom_address is seen one cycle later.
    always_ff @(posedge clk) begin
        if (reset) rom_data <= '0;
        else       rom_data <= mem[rom_address];
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboarded bench for uart_boot_loader driving 8N1 frames on uart_rx.
module tb_uart_boot_loader;
    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 100000;
    localparam int ADDR_W = 8;
    localparam int TMO    = 3000;
    localparam int CPB    = CLK_HZ / BAUD;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              uart_rx = 1'b1;
    logic [ADDR_W-1:0] rom_address = '0;
    logic [31:0]       rom_data;
    logic              cpu_enable, load_error;
    logic [ADDR_W:0]   words_loaded;

    int checks = 0;
    int passes = 0;
    int bv_count = 0;
    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_rom[$];
    logic [7:0]  mon_exp;
    logic [31:0] rd_exp;
    bit          seen;

    always #5 clk = ~clk;

    uart_boot_loader #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .rom_address(rom_address),
        .rom_data(rom_data), .cpu_enable(cpu_enable), .load_error(load_error),
        .words_loaded(words_loaded)
    );

    // Every received byte is matched against the byte queue filled by send_byte.
    always @(negedge clk) begin
        if (dut.byte_valid) begin
            bv_count++;
            checks++;
            if (exp_bytes.size() == 0) begin
                $display("FAIL rx_byte: got unexpected byte %02h, expected none", dut.byte_data);
            end else begin
                mon_exp = exp_bytes.pop_front();
                if (dut.byte_data !== mon_exp)
                    $display("FAIL rx_byte: got %02h expected %02h", dut.byte_data, mon_exp);
                else passes++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        if (stop_bit) exp_bytes.push_back(b);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_spec_frame(input logic corrupt);
        logic [7:0] body [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        logic [7:0] sum = 8'h00;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        for (int i = 0; i < 8; i++) begin
            sum += body[i];
            send_byte(body[i], 1'b1);
        end
        send_byte(corrupt ? 8'hB8 : sum, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (rom_data !== 32'h0) $display("FAIL reset_rom_data: got %h expected 0", rom_data); else passes++;
        checks++; if (cpu_enable !== 1'b0) $display("FAIL reset_cpu_enable: got %b expected 0", cpu_enable); else passes++;
        checks++; if (load_error !== 1'b0) $display("FAIL reset_load_error: got %b expected 0", load_error); else passes++;
        checks++; if (words_loaded !== '0) $display("FAIL reset_words_loaded: got %0d expected 0", words_loaded); else passes++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_load();
        send_spec_frame(1'b0);
        checks++; if (cpu_enable !== 1'b1) $display("FAIL load_cpu_enable: got %b expected 1", cpu_enable); else passes++;
        checks++; if (load_error !== 1'b0) $display("FAIL load_error_clear: got %b expected 0", load_error); else passes++;
        checks++; if (words_loaded !== 9'd2) $display("FAIL load_words: got %0d expected 2", words_loaded); else passes++;
        // rom_address has been 0, so rom_data currently shows word 0.
        rom_address = 8'd1;
        exp_rom.push_back(32'h00100093);
        checks++; if (rom_data !== 32'h00000013) $display("FAIL read_before_edge: got %h expected 00000013", rom_data); else passes++;
        @(posedge clk); #1;
        rd_exp = exp_rom.pop_front();
        checks++; if (rom_data !== rd_exp) $display("FAIL read_word1: got %h expected %h", rom_data, rd_exp); else passes++;
        @(negedge clk);
        rom_address = 8'd0;
        exp_rom.push_back(32'h00000013);
        @(posedge clk); #1;
        rd_exp = exp_rom.pop_front();
        checks++; if (rom_data !== rd_exp) $display("FAIL read_word0: got %h expected %h", rom_data, rd_exp); else passes++;
    endtask

    task automatic test_bad_checksum();
        send_spec_frame(1'b1);
        checks++; if (cpu_enable !== 1'b0) $display("FAIL badsum_cpu_enable: got %b expected 0", cpu_enable); else passes++;
        checks++; if (load_error !== 1'b1) $display("FAIL badsum_load_error: got %b expected 1", load_error); else passes++;
        send_spec_frame(1'b0);
        checks++; if (load_error !== 1'b0) $display("FAIL recover_load_error: got %b expected 0", load_error); else passes++;
        checks++; if (cpu_enable !== 1'b1) $display("FAIL recover_cpu_enable: got %b expected 1", cpu_enable); else passes++;
    endtask

    task automatic test_framing();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        checks++; if (load_error !== 1'b1) $display("FAIL framing_load_error: got %b expected 1", load_error); else passes++;
        checks++; if (cpu_enable !== 1'b0) $display("FAIL framing_cpu_enable: got %b expected 0", cpu_enable); else passes++;
    endtask

    task automatic test_timeout();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        for (int i = 1; i <= 5; i++) send_byte(8'(i * 8'h11), 1'b1);
        checks++; if (load_error !== 1'b0) $display("FAIL timeout_sync_clears: got %b expected 0", load_error); else passes++;
        repeat (TMO - 200) @(negedge clk);
        checks++; if (load_error !== 1'b0) $display("FAIL timeout_early: got %b expected 0", load_error); else passes++;
        repeat (400) @(negedge clk);
        checks++; if (load_error !== 1'b1) $display("FAIL timeout_load_error: got %b expected 1", load_error); else passes++;
        checks++; if (cpu_enable !== 1'b0) $display("FAIL timeout_cpu_enable: got %b expected 0", cpu_enable); else passes++;
        rom_address = 8'd0;
        exp_rom.push_back(32'h44332211);
        @(posedge clk); #1;
        rd_exp = exp_rom.pop_front();
        checks++; if (rom_data !== rd_exp) $display("FAIL partial_word0: got %h expected %h", rom_data, rd_exp); else passes++;
        @(negedge clk);
        rom_address = 8'd1;
        exp_rom.push_back(32'h00100093);
        @(posedge clk); #1;
        rd_exp = exp_rom.pop_front();
        checks++; if (rom_data !== rd_exp) $display("FAIL partial_word1: got %h expected %h", rom_data, rd_exp); else passes++;
    endtask

    task automatic test_reload();
        send_spec_frame(1'b0);
        checks++; if (cpu_enable !== 1'b1) $display("FAIL reload_pre_enable: got %b expected 1", cpu_enable); else passes++;
        seen = 1'b0;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                for (int i = 0; i < CPB * 12; i++) begin
                    @(negedge clk);
                    if (dut.byte_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                checks++;
                if (!seen) $display("FAIL reload_sync_seen: got no byte_valid expected one within %0d cycles", CPB * 12);
                else if (cpu_enable !== 1'b1) $display("FAIL reload_enable_at_sync: got %b expected 1", cpu_enable);
                else passes++;
                @(negedge clk);
                checks++; if (cpu_enable !== 1'b0) $display("FAIL reload_enable_drop: got %b expected 0", cpu_enable); else passes++;
            end
        join
        send_byte(8'h01, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'hFF, 1'b1);
        send_byte(8'hFC, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (cpu_enable !== 1'b1) $display("FAIL reload_cpu_enable: got %b expected 1", cpu_enable); else passes++;
        checks++; if (words_loaded !== 9'd1) $display("FAIL reload_words: got %0d expected 1", words_loaded); else passes++;
        rom_address = 8'd0;
        exp_rom.push_back(32'hFFFFFFFF);
        @(posedge clk); #1;
        rd_exp = exp_rom.pop_front();
        checks++; if (rom_data !== rd_exp) $display("FAIL reload_word0: got %h expected %h", rom_data, rd_exp); else passes++;
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        rom_address = 8'd1;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (rom_data !== 32'h0) $display("FAIL midreset_rom_data: got %h expected 0", rom_data); else passes++;
        checks++; if (words_loaded !== '0) $display("FAIL midreset_words: got %0d expected 0", words_loaded); else passes++;
        checks++; if (cpu_enable !== 1'b0 || load_error !== 1'b0)
            $display("FAIL midreset_flags: got en=%b err=%b expected 0 0", cpu_enable, load_error); else passes++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        send_spec_frame(1'b0);
        checks++; if (cpu_enable !== 1'b1) $display("FAIL midreset_reload_enable: got %b expected 1", cpu_enable); else passes++;
        checks++; if (words_loaded !== 9'd2) $display("FAIL midreset_reload_words: got %0d expected 2", words_loaded); else passes++;
        exp_rom.push_back(32'h00100093);
        @(posedge clk); #1;
        rd_exp = exp_rom.pop_front();
        checks++; if (rom_data !== rd_exp) $display("FAIL midreset_word1: got %h expected %h", rom_data, rd_exp); else passes++;
    endtask

    task automatic test_glitch();
        int bv_before;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        bv_before = bv_count;
        uart_rx = 1'b0;
        repeat ((CPB * 3) / 10) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checks++; if (bv_count !== bv_before) $display("FAIL glitch_no_byte: got %0d bytes expected 0", bv_count - bv_before); else passes++;
        checks++; if (load_error !== 1'b0) $display("FAIL glitch_no_error: got %b expected 0", load_error); else passes++;
        send_spec_frame(1'b0);
        checks++; if (cpu_enable !== 1'b1) $display("FAIL glitch_then_load: got %b expected 1", cpu_enable); else passes++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_bad_checksum();
        test_framing();
        test_timeout();
        test_reload();
        test_reset_mid_frame();
        test_glitch();
        checks++;
        if (exp_bytes.size() != 0) $display("FAIL bytes_drained: got %0d pending expected 0", exp_bytes.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
